// File: rtl/cpu_pkg.sv
// Shared CPU constants and register-file types.
// READ_DELAY/WRITE_DELAY are the behavioural timing figures used by benches.
package cpu_pkg;
    localparam int DATA_WIDTH  = 8;
    localparam int ADDR_WIDTH  = 3;
    localparam int DEPTH       = 1 << ADDR_WIDTH;
    localparam int READ_DELAY  = 2;
    localparam int WRITE_DELAY = 1;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    typedef enum logic {
        IDLE,
        CLEARING
    } regfile_state_t;
endpackage

// File: rtl/reg_file_if.sv
// Register-file bus: write-back, two read ports, clear and status.
interface reg_file_if;
    import cpu_pkg::*;

    data_t IN;
    addr_t INADDRESS;
    logic  WRITE;
    addr_t OUT1ADDRESS;
    addr_t OUT2ADDRESS;
    logic  CLEAR;
    data_t OUT1;
    data_t OUT2;
    logic  WRITE_ACK;
    logic  BUSY;

    modport master (
        output IN, INADDRESS, WRITE,
        output OUT1ADDRESS, OUT2ADDRESS, CLEAR,
        input  OUT1, OUT2, WRITE_ACK, BUSY
    );

    modport slave (
        input  IN, INADDRESS, WRITE,
        input  OUT1ADDRESS, OUT2ADDRESS, CLEAR,
        output OUT1, OUT2, WRITE_ACK, BUSY
    );
endinterface

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear sequencer: walks one register per cycle from r0 to r(DEPTH-1).
module regfile_clear_fsm
    import cpu_pkg::*;
(
    input  logic  CLK,
    input  logic  RESET,
    input  logic  CLEAR,
    output logic  BUSY,
    output logic  clr_en,
    output addr_t clr_idx
);

    regfile_state_t state_q, state_d;
    addr_t          cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_en  = 1'b0;
        clr_idx = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (CLEAR) begin
                    state_d = CLEARING;
                    cnt_d   = '0;
                end
            end
            CLEARING: begin
                clr_en = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == addr_t'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign BUSY = (state_q == CLEARING);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/reg_file.sv
// 8x8 architectural register file with write-ack and bulk clear.
// Optional same-cycle write-through forwarding: REGFILE_BYPASS_EN.
module reg_file
    import cpu_pkg::*;
(
    input logic       CLK,
    input logic       RESET,
    reg_file_if.slave bus
);

    data_t regs_q [DEPTH];
    data_t regs_d [DEPTH];
    logic  ack_q, ack_d;
    logic  busy;
    logic  clr_en;
    addr_t clr_idx;
    logic  wr_en;
    logic  fwd1, fwd2;

    regfile_clear_fsm u_clear_fsm (
        .CLK     (CLK),
        .RESET   (RESET),
        .CLEAR   (bus.CLEAR),
        .BUSY    (busy),
        .clr_en  (clr_en),
        .clr_idx (clr_idx)
    );

    // A clear request in IDLE wins over a coincident write.
    assign wr_en = !busy && bus.WRITE && !bus.CLEAR;

    always_comb begin
        regs_d = regs_q;
        ack_d  = wr_en;
        if (clr_en) begin
            regs_d[clr_idx] = '0;
        end else if (wr_en) begin
            regs_d[bus.INADDRESS] = bus.IN;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            regs_q <= '{default: '0};
            ack_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            ack_q  <= ack_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign fwd1 = wr_en && (bus.INADDRESS == bus.OUT1ADDRESS);
    assign fwd2 = wr_en && (bus.INADDRESS == bus.OUT2ADDRESS);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    assign bus.OUT1      = fwd1 ? bus.IN : regs_q[bus.OUT1ADDRESS];
    assign bus.OUT2      = fwd2 ? bus.IN : regs_q[bus.OUT2ADDRESS];
    assign bus.WRITE_ACK = ack_q;
    assign bus.BUSY      = busy;

endmodule

// File: tb/tb_reg_file.sv
// Randomised scoreboard bench for reg_file against an array-based model.
module tb_reg_file;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    event chk_ev;

    reg_file_if bus ();

    reg_file u_dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] o1;
        logic [7:0] o2;
        logic       ack;
        logic       busy;
    } exp_t;

    exp_t q[$];

    // Reference model: register array plus "cycles of clearing left".
    logic [7:0] m_regs [8];
    int         busy_left;
    bit         m_ack;

    function automatic void m_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        busy_left = 0;
        m_ack = 0;
    endfunction

    function automatic void m_step(bit w, int a, logic [7:0] d, bit c);
        if (busy_left > 0) begin
            m_regs[8 - busy_left] = 8'h00;
            busy_left--;
            m_ack = 0;
        end else if (c) begin
            busy_left = 8;
            m_ack = 0;
        end else if (w) begin
            m_regs[a] = d;
            m_ack = 1;
        end else begin
            m_ack = 0;
        end
    endfunction

    function automatic logic [7:0] m_read(int r, bit w, int a,
                                          logic [7:0] d, bit c);
`ifdef REGFILE_BYPASS_EN
        if (w && !c && busy_left == 0 && a == r) return d;
`endif
        return m_regs[r];
    endfunction

    task automatic push_exp(int r1, int r2, bit w, int a,
                            logic [7:0] d, bit c);
        exp_t e;
        e.cyc  = cyc;
        e.o1   = m_read(r1, w, a, d, c);
        e.o2   = m_read(r2, w, a, d, c);
        e.ack  = m_ack;
        e.busy = (busy_left > 0);
        q.push_back(e);
    endtask

    // Called at posedge+1; drives one cycle and advances the model.
    task automatic cycle(bit w, int a, logic [7:0] d, bit c,
                         int r1, int r2);
        bus.WRITE       = w;
        bus.INADDRESS   = 3'(a);
        bus.IN          = d;
        bus.CLEAR       = c;
        bus.OUT1ADDRESS = 3'(r1);
        bus.OUT2ADDRESS = 3'(r2);
        push_exp(r1, r2, w, a, d, c);
        @(posedge CLK);
        m_step(w, a, d, c);
        #1;
    endtask

    // Asynchronous mid-cycle reset, checked 2 units later before any edge.
    task automatic reset_pulse(int r1, int r2);
        bus.WRITE       = 1'b0;
        bus.CLEAR       = 1'b0;
        bus.OUT1ADDRESS = 3'(r1);
        bus.OUT2ADDRESS = 3'(r2);
        #1 RESET = 1'b1;
        m_reset();
        #2;
        push_exp(r1, r2, 1'b0, 0, 8'h00, 1'b0);
        ->chk_ev;
        @(negedge CLK);
        #1 RESET = 1'b0;
        @(posedge CLK);
        m_step(1'b0, 0, 8'h00, 1'b0);
        #1;
    endtask

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp, int c);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, c, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK or chk_ev);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                if (e.cyc != cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL stale_item cyc=%0d got=%0d want=%0d",
                             cyc, e.cyc, cyc);
                end else begin
                    chk("out1", bus.OUT1, e.o1, e.cyc);
                    chk("out2", bus.OUT2, e.o2, e.cyc);
                    chk("write_ack", 8'(bus.WRITE_ACK), 8'(e.ack), e.cyc);
                    chk("busy", 8'(bus.BUSY), 8'(e.busy), e.cyc);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bus.WRITE = 0;
        bus.CLEAR = 0;
        bus.IN = 0;
        bus.INADDRESS = 0;
        bus.OUT1ADDRESS = 0;
        bus.OUT2ADDRESS = 0;
        m_reset();
        @(posedge CLK);
        #1;
        reset_pulse(0, 7);

        // single write, ack lasts one cycle
        cycle(1, 3, 8'h2A, 0, 3, 3);
        cycle(0, 0, 8'h00, 0, 3, 3);
        cycle(0, 0, 8'h00, 0, 3, 3);

        // back-to-back writes
        cycle(1, 0, 8'h01, 0, 0, 1);
        cycle(1, 1, 8'h0B, 0, 0, 1);
        cycle(0, 0, 8'h00, 0, 0, 1);
        cycle(0, 0, 8'h00, 0, 0, 1);

        // reset with preloaded registers
        reset_pulse(3, 1);
        cycle(0, 0, 8'h00, 0, 3, 0);

        // fill, then clear with writes/clears attempted mid-sequence
        for (int i = 0; i < 8; i++)
            cycle(1, i, 8'((i + 1) * 8'h11), 0, i, 7);
        cycle(0, 0, 8'h00, 1, 7, 0);
        for (int i = 0; i < 9; i++)
            cycle(1, $urandom_range(0, 7), 8'($urandom), i == 3,
                  7, $urandom_range(0, 7));
        cycle(0, 0, 8'h00, 0, 7, 6);

        // clear and write on the same edge
        cycle(1, 2, 8'h44, 0, 2, 2);
        cycle(1, 2, 8'hFF, 1, 2, 2);
        for (int i = 0; i < 8; i++)
            cycle(0, 0, 8'h00, 0, 2, i);
        cycle(0, 0, 8'h00, 0, 2, 2);

        // reset in the middle of a clear
        for (int i = 0; i < 8; i++)
            cycle(1, i, 8'($urandom_range(1, 255)), 0, i, 0);
        cycle(0, 0, 8'h00, 1, 7, 6);
        for (int i = 0; i < 4; i++)
            cycle(0, 0, 8'h00, 0, 7, i);
        reset_pulse(7, 6);
        cycle(1, 5, 8'h5A, 0, 5, 7);
        cycle(0, 0, 8'h00, 0, 5, 6);
        cycle(0, 0, 8'h00, 0, 5, 5);

        // write with matching read address (forwarded when bypass on)
        cycle(1, 4, 8'h77, 0, 4, 1);
        cycle(0, 0, 8'h00, 0, 4, 4);

        // randomised traffic
        for (int i = 0; i < 120; i++)
            cycle($urandom_range(0, 1), $urandom_range(0, 7),
                  8'($urandom), $urandom_range(0, 24) == 0,
                  $urandom_range(0, 7), $urandom_range(0, 7));
        cycle(0, 0, 8'h00, 0, 0, 0);

        @(negedge CLK);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file for the 8-bit single-cycle CPU.
- Read side: sources the two ALU operands, DATA1 and DATA2.
- Write side: accepts the ALU RESULT for write-back.
- Adds a multi-cycle CLEAR sequencer and a write-acknowledge, so the control unit can sequence write-back and bulk clear.

Parameters:
- DATA_WIDTH, 8, width of each register and of the IN/OUT buses.
- ADDR_WIDTH, 3, register address width; DEPTH = 2**ADDR_WIDTH = 8 registers.
- READ_DELAY, 2, simulation delay (time units) from address/data change to OUT1/OUT2 update.
- WRITE_DELAY, 1, simulation delay from CLK posedge to register update.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- IN  input  DATA_WIDTH  write-back data (ALU RESULT).
- INADDRESS  input  ADDR_WIDTH  destination register.
- WRITE  input  1  write enable, sampled at CLK posedge.
- OUT1ADDRESS  input  ADDR_WIDTH  source register for operand 1.
- OUT2ADDRESS  input  ADDR_WIDTH  source register for operand 2.
- CLEAR  input  1  request to zero all registers, sampled at posedge.
- OUT1  output  DATA_WIDTH  operand 1 (feeds ALU DATA1).
- OUT2  output  DATA_WIDTH  operand 2 (feeds ALU DATA2).
- WRITE_ACK  output  1  one-cycle pulse: a write was committed on the previous edge.
- BUSY  output  1  high while the clear sequence runs.

Behaviour:
- Reset:
  - One clock; RESET is asynchronous and active-high.
  - On RESET rising, immediately: all registers = 0, state = IDLE, clear counter = 0, WRITE_ACK = 0, BUSY = 0.
  - OUT1/OUT2 read 0 after READ_DELAY.
  - RESET held high: all edges are ignored.
- Reads:
  - Combinational and asynchronous.
  - OUTn = reg[OUTnADDRESS], updated READ_DELAY after any change of address or register contents.
  - Both ports may read the same register.
- Writes:
  - In IDLE, at a posedge with WRITE=1 and CLEAR=0: reg[INADDRESS] = IN after WRITE_DELAY.
  - WRITE_ACK = 1 for exactly that following cycle, then 0.
  - Back-to-back writes give a continuous WRITE_ACK high, one cycle per write.
- FSM states: IDLE, CLEARING.
  - IDLE -> CLEARING: posedge with CLEAR=1. Counter = 0, BUSY = 1 from that edge.
  - CLEARING, each posedge: reg[counter] = 0, counter += 1.
  - Counter reaches DEPTH-1 and that register is cleared -> IDLE, BUSY = 0, counter wraps to 0.
  - The clear takes exactly DEPTH = 8 cycles.
- Simultaneous events:
  - CLEAR and WRITE at the same IDLE edge: CLEAR wins, the write is dropped, WRITE_ACK stays 0.
  - WRITE during CLEARING: ignored, WRITE_ACK = 0.
  - CLEAR during CLEARING: ignored; the sequence does not restart.
  - Reads during CLEARING return the current contents: already-cleared registers read 0, others keep their old value.
- Reset mid-clear: state IDLE, all registers 0, counter 0 immediately.
- No arithmetic beyond the counter. The counter is ADDR_WIDTH bits and wraps modulo DEPTH.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - When WRITE=1, state is IDLE, CLEAR=0 and INADDRESS == OUTnADDRESS, OUTn shows IN (after READ_DELAY) instead of the stored value.
  - Gives same-cycle write-through forwarding.
  - The bypass is disabled during CLEARING.
- Undefined: OUTn always reflects stored contents; a new value is visible only after the write edge plus WRITE_DELAY.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_WIDTH and ADDR_WIDTH constants, shared with the ALU;
  - READ_DELAY and WRITE_DELAY constants;
  - state typedef regfile_state_t {IDLE, CLEARING}.
- One natural sub-module, regfile_clear_fsm, owns:
  - inputs: CLK, RESET, CLEAR;
  - outputs: BUSY, clear-enable, clear-index.
- The parent holds the storage array, the read muxes, the write logic and WRITE_ACK.

Test Plan:
- RESET pulse mid-cycle with registers preloaded -> OUT1 = OUT2 = 8'h00 by +2, BUSY = 0, WRITE_ACK = 0 without waiting for CLK.
- Write 8'h2A to r3, then read OUT1ADDRESS = 3, OUT2ADDRESS = 3 -> both 8'h2A; WRITE_ACK high exactly one cycle after the write edge.
- Writes r0 = 8'h01, r1 = 8'h0B on consecutive edges -> WRITE_ACK high two cycles; OUT1(r0) = 8'h01, OUT2(r1) = 8'h0B.
- Fill r0..r7 = 8'h11..8'h88, pulse CLEAR -> BUSY high exactly 8 cycles; r7 still 8'h88 after edge 7 of CLEARING, 0 after edge 8; a WRITE during CLEARING gives no WRITE_ACK and no change.
- CLEAR and WRITE(r2 = 8'hFF) on the same edge -> write dropped; r2 reads 0 after the sequence.
- RESET asserted at clear cycle 4 -> BUSY = 0 immediately, all registers 0; a subsequent WRITE r5 = 8'h5A is acknowledged normally.
- Additional case with REGFILE_BYPASS_EN defined: WRITE=1, IN = 8'h77, INADDRESS = OUT1ADDRESS = 4 -> OUT1 = 8'h77 before the clock edge.
